mac_int: RTL and testbench

MAC_INT -- requirements
Module: mac_int

---
 rtl/mac_int_pkg.sv | 9 +
 rtl/mac_pipe_delay.sv | 39 +++
 rtl/mac_int.sv | 62 ++++++
 tb/tb_mac_int.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mac_int_pkg.sv
// Shared helpers for the signed multiply-accumulate slice.
// Widths are derived from the top-level parameters, so only a width helper lives here.
package mac_int_pkg;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mac_pipe_delay.sv
// Generic DEPTH-stage register pipeline with synchronous active-high clear.
// Reused for the product, addend-alignment and sum paths of mac_int.
module mac_pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is cleared on reset (not just the output) so no operand
  // in flight when rst rises can ever reach z afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment lets every stage shift from the
      // previous-cycle values simultaneously.
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_int.sv
// Pipelined signed z = a*b + c with MULT_LATENCY product stages and
// ADDER_LATENCY sum stages; c is delayed alongside its own product.
module mac_int
  import mac_int_pkg::*;
#(
  parameter int A_width       = 8,
  parameter int B_width       = 8,
  parameter int SUM_width     = 32,
  parameter int MULT_LATENCY  = 1,
  parameter int ADDER_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_width-1:0]   a,
  input  logic [B_width-1:0]   b,
  input  logic [SUM_width-1:0] c,
  output logic [SUM_width-1:0] z
);

  localparam int PROD_W = A_width + B_width;
  localparam int ADD_W  = max_int(PROD_W, SUM_width);

  logic signed [PROD_W-1:0] prod;
  logic        [PROD_W-1:0] prod_pipe;
  logic        [SUM_width-1:0] c_pipe;
  logic signed [ADD_W-1:0]  sum_full;
  logic        [SUM_width-1:0] sum_trunc;

  // Both operands are sign-extended to the full product width first, so
  // most-negative squared stays a positive product.
  always_comb begin
    prod = PROD_W'($signed(a)) * PROD_W'($signed(b));
  end

  mac_pipe_delay #(.WIDTH(PROD_W), .DEPTH(MULT_LATENCY)) u_prod_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (prod),
    .dout (prod_pipe)
  );

  mac_pipe_delay #(.WIDTH(SUM_width), .DEPTH(MULT_LATENCY)) u_c_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (c),
    .dout (c_pipe)
  );

  // Sum at the wider of product/result width, then wrap to SUM_width.
  always_comb begin
    sum_full  = ADD_W'($signed(prod_pipe)) + ADD_W'($signed(c_pipe));
    sum_trunc = sum_full[SUM_width-1:0];
  end

  mac_pipe_delay #(.WIDTH(SUM_width), .DEPTH(ADDER_LATENCY)) u_sum_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (sum_trunc),
    .dout (z)
  );

endmodule

// File: tb/tb_mac_int.sv
// Scoreboard bench for mac_int: default build, a 16-bit result build and a
// 3+2 latency build share the same stimulus and reset.
module tb_mac_int;

  logic               clk;
  logic               rst;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic signed [31:0] c;
  logic        [15:0] c16;
  logic        [31:0] z_d;
  logic        [15:0] z_w;
  logic        [31:0] z_l;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb_d [$];
  logic [15:0] sb_w [$];
  logic [31:0] sb_l [$];

  assign c16 = c[15:0];

  mac_int dut_d (
    .clk (clk), .rst (rst), .a (a), .b (b), .c (c), .z (z_d)
  );

  mac_int #(.SUM_width(16)) dut_w (
    .clk (clk), .rst (rst), .a (a), .b (b), .c (c16), .z (z_w)
  );

  mac_int #(.MULT_LATENCY(3), .ADDER_LATENCY(2)) dut_l (
    .clk (clk), .rst (rst), .a (a), .b (b), .c (c), .z (z_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model32(input logic signed [7:0] ai,
                                          input logic signed [7:0] bi,
                                          input logic signed [31:0] ci);
    return 32'(int'(ai) * int'(bi) + int'(ci));
  endfunction

  function automatic logic [15:0] model16(input logic signed [7:0] ai,
                                          input logic signed [7:0] bi,
                                          input logic signed [31:0] ci);
    logic signed [15:0] c_lo;
    c_lo = ci[15:0];
    return 16'(int'(ai) * int'(bi) + int'(c_lo));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Drive one cycle of stimulus, record what each build must show after the
  // edge, then compare the oldest pending expectation against z.
  task automatic tick(input string ph, input logic r, input logic signed [7:0] ai,
                      input logic signed [7:0] bi, input logic signed [31:0] ci);
    logic [31:0] e32;
    logic [15:0] e16;
    rst = r;
    a   = ai;
    b   = bi;
    c   = ci;
    @(posedge clk);
    if (r) begin
      sb_d.delete();
      sb_w.delete();
      sb_l.delete();
      repeat (2) begin
        sb_d.push_back('0);
        sb_w.push_back('0);
      end
      repeat (5) sb_l.push_back('0);
    end else begin
      sb_d.push_back(model32(ai, bi, ci));
      sb_w.push_back(model16(ai, bi, ci));
      sb_l.push_back(model32(ai, bi, ci));
    end
    #1;
    if (sb_d.size() > 0) begin
      e32 = sb_d.pop_front();
      check({ph, "/def"}, z_d, e32);
    end
    if (sb_w.size() > 0) begin
      e16 = sb_w.pop_front();
      check({ph, "/w16"}, {{16{z_w[15]}}, z_w}, {{16{e16[15]}}, e16});
    end
    if (sb_l.size() > 0) begin
      e32 = sb_l.pop_front();
      check({ph, "/lat5"}, z_l, e32);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    c   = '0;

    // Reset held with live operands, then release with the same operands.
    repeat (3) tick("rst", 1'b1, 8'sd5, 8'sd7, 32'sd9);
    repeat (6) tick("rel", 1'b0, 8'sd5, 8'sd7, 32'sd9);

    // Signed corners, wrap-around on the 16-bit build, small latency case.
    tick("neg",  1'b0, -8'sd3,   8'sd4,   32'sd100);
    tick("mneg", 1'b0, -8'sd128, -8'sd128, 32'sd0);
    tick("wrap", 1'b0, 8'sd127,  8'sd127, 32'sd32767);
    tick("lat",  1'b0, 8'sd2,    8'sd2,   32'sd1);

    // Back-to-back stream.
    tick("str", 1'b0, 8'sd1,  8'sd1, 32'sd0);
    tick("str", 1'b0, 8'sd2,  8'sd3, 32'sd1);
    tick("str", 1'b0, -8'sd1, 8'sd5, -32'sd10);
    repeat (6) tick("drain", 1'b0, 8'sd0, 8'sd0, 32'sd0);

    // Random stream with a one-cycle reset in the middle.
    repeat (20) tick("rnd", 1'b0, 8'($urandom), 8'($urandom), 32'($urandom));
    tick("mrst", 1'b1, 8'($urandom), 8'($urandom), 32'($urandom));
    repeat (20) tick("post", 1'b0, 8'($urandom), 8'($urandom), 32'($urandom));
    repeat (6) tick("end", 1'b0, 8'sd0, 8'sd0, 32'sd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
